// File: rtl/borrow_lookahead_subtractor_seq.sv
// Multi-cycle WIDTH-bit subtractor: D = A - B - Bin, one 4-bit slice per cycle.
// Each slice resolves its internal borrows with two-level look-ahead logic; a
// registered borrow carries the result from one slice to the next.
// Optional feature: define BLS_OVF_EN to compute signed overflow on the ovf port.
// Without it, ovf is tied low and no overflow logic is built.
module borrow_lookahead_subtractor_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             ovf
);

    // WIDTH must be a multiple of 4 and at least 4.
    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic              borrow_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  d_q;
    logic              bout_q;
    logic              out_valid_q;

    logic [3:0] a_s;
    logic [3:0] b_s;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] bc;
    logic [3:0] d_s;
    logic       last_slice;

    assign last_slice = (cnt_q == LAST);

    // Select the slice of the latched operands addressed by the slice counter.
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int k = 0; k < int'(NSLICE); k++) begin
            if (cnt_q == CW'(k)) begin
                a_s = a_q[4*k +: 4];
                b_s = b_q[4*k +: 4];
            end
        end
    end

    // Slice look-ahead: generate when a=0,b=1; propagate an incoming borrow when a==b.
    always_comb begin
        g     = ~a_s & b_s;
        p     = ~(a_s ^ b_s);
        bc[0] = borrow_q;
        bc[1] = g[0] | (p[0] & bc[0]);
        bc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bc[0]);
        bc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bc[0]);
        bc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bc[0]);
        d_s   = a_s ^ b_s ^ bc[3:0];
    end

    // Control FSM and datapath registers; outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= Bin;
                        cnt_q    <= '0;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    // D is updated in place; high slices keep stale data until reached.
                    for (int k = 0; k < int'(NSLICE); k++) begin
                        if (cnt_q == CW'(k)) begin
                            d_q[4*k +: 4] <= d_s;
                        end
                    end
                    borrow_q <= bc[4];
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_slice) begin
                        bout_q      <= bc[4];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

`ifdef BLS_OVF_EN
    logic ovf_q;

    // Signed overflow: operand signs differ and the result sign differs from A.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == StBusy && last_slice) begin
            ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_s[3] != a_q[WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign Bout      = bout_q;

endmodule

// File: tb/tb_borrow_lookahead_subtractor_seq.sv
// Self-checking bench for borrow_lookahead_subtractor_seq (WIDTH=16).
// Reference results come from plain 17-bit and signed integer arithmetic.
module tb_borrow_lookahead_subtractor_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         Bout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    borrow_lookahead_subtractor_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic bin, output logic [W-1:0] d,
                                  output logic bo, output logic ov);
        logic [W:0] r;
        int sa;
        int sb;
        int s;
        r  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        d  = r[W-1:0];
        bo = r[W];
        sa = $signed(a);
        sb = $signed(b);
        s  = sa - sb - int'(bin);
`ifdef BLS_OVF_EN
        ov = (s > 32767) || (s < -32768);
`else
        ov = 1'b0;
`endif
    endfunction

    // Runs one operation; scrambles inputs after accept, stalls the consumer.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input int stall, output logic [W-1:0] d, output logic bo,
                          output logic ov, output int lat);
        int w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        A = a;
        B = b;
        Bin = bin;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        Bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        repeat (stall) step();
        d  = D;
        bo = Bout;
        ov = ovf;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        Bin = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        end
        checks++;
        if (D !== '0 || Bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: D=%h Bout=%b ovf=%b, need 0 0 0", D, Bout, ovf);
        end
    endtask

    task automatic test_directed();
        vec_t v[6];
        logic [W-1:0] d;
        logic bo;
        logic ov;
        logic ov_exp;
        int lat;
        v[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
        v[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        v[2] = '{16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        v[3] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0};
        v[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        v[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].a, v[i].b, v[i].bin, 0, d, bo, ov, lat);
`ifdef BLS_OVF_EN
            ov_exp = v[i].ov;
`else
            ov_exp = 1'b0;
`endif
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d cycles, need 4", i, lat);
            end
            checks++;
            if (d !== v[i].d || bo !== v[i].bo || ov !== ov_exp) begin
                errors++;
                $display("FAIL dir%0d_result: D=%h Bout=%b ovf=%b, need %h %b %b",
                         i, d, bo, ov, v[i].d, v[i].bo, ov_exp);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic bin;
        logic [W-1:0] d;
        logic bo;
        logic ov;
        logic [W-1:0] ed;
        logic ebo;
        logic eov;
        logic [W-1:0] corner[4];
        int lat;
        corner[0] = 16'h0000;
        corner[1] = 16'hFFFF;
        corner[2] = 16'h8000;
        corner[3] = 16'h7FFF;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
            b = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
            bin = 1'($urandom);
            run_op(a, b, bin, $urandom_range(3), d, bo, ov, lat);
            model(a, b, bin, ed, ebo, eov);
            checks++;
            if (lat !== 4 || d !== ed || bo !== ebo || ov !== eov) begin
                errors++;
                $display("FAIL rand%0d: %h-%h-%b lat=%0d D=%h Bout=%b ovf=%b, need 4 %h %b %b",
                         i, a, b, bin, lat, d, bo, ov, ed, ebo, eov);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ed;
        logic ebo;
        logic eov;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        logic bin2;
        int n;
        A = 16'hC3A5;
        B = 16'h5A3C;
        Bin = 1'b1;
        model(A, B, Bin, ed, ebo, eov);
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        a2 = W'($urandom);
        b2 = W'($urandom);
        bin2 = 1'($urandom);
        A = a2;
        B = b2;
        Bin = bin2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (D !== ed || Bout !== ebo || ovf !== eov || in_ready !== 1'b0
                || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: D=%h Bout=%b ovf=%b rdy=%b vld=%b, need %h %b %b 0 1",
                         i, D, Bout, ovf, in_ready, out_valid, ed, ebo, eov);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        model(a2, b2, bin2, ed, ebo, eov);
        checks++;
        if (n !== 4 || D !== ed || Bout !== ebo || ovf !== eov) begin
            errors++;
            $display("FAIL bp_next: lat=%0d D=%h Bout=%b ovf=%b, need 4 %h %b %b",
                     n, D, Bout, ovf, ed, ebo, eov);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ed;
        logic ebo;
        logic eov;
        logic [W-1:0] cd;
        logic cbo;
        int n;
        out_ready = 1'b1;
        for (int op = 0; op < 2; op++) begin
            A = W'($urandom);
            B = W'($urandom);
            Bin = 1'($urandom);
            model(A, B, Bin, ed, ebo, eov);
            in_valid = 1'b1;
            step();
            n = 0;
            cd = 'x;
            cbo = 1'bx;
            while (!in_ready && n < 20) begin
                step();
                n++;
                if (out_valid) begin
                    cd = D;
                    cbo = Bout;
                end
            end
            checks++;
            if (n !== 5 || cd !== ed || cbo !== ebo) begin
                errors++;
                $display("FAIL b2b%0d: rearm=%0d D=%h Bout=%b, need 5 %h %b",
                         op, n, cd, cbo, ed, ebo);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        logic bo;
        logic ov;
        int lat;
        A = 16'hFFFF;
        B = 16'h1111;
        Bin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || D !== '0 || Bout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: vld=%b D=%h Bout=%b rdy=%b, need 0 0000 0 1",
                     out_valid, D, Bout, in_ready);
        end
        run_op(16'h00FF, 16'h0100, 1'b0, 1, d, bo, ov, lat);
        checks++;
        if (lat !== 4 || d !== 16'hFFFF || bo !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: lat=%0d D=%h Bout=%b ovf=%b, need 4 ffff 1 0",
                     lat, d, bo, ov);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/borrow_lookahead_subtractor_seq.md
Name: borrow_lookahead_subtractor_seq

Overview:
- Multi-cycle wide subtractor computing D = A - B - Bin on WIDTH-bit unsigned operands.
- Processes one 4-bit slice per cycle; each slice uses borrow look-ahead logic, and a registered borrow links one slice to the next.
- Valid/ready handshake on both input and output, so it drops into datapaths beside the existing 4-bit adders.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; NSLICE = WIDTH/4.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- D  output  WIDTH  difference.
- Bout  output  1  borrow out: 1 iff A < B + Bin (unsigned).
- ovf  output  1  signed overflow; see Optional Feature.

Behaviour:
- Reset: rst_n sampled low at a rising edge forces:
  - state=IDLE, slice counter=0, borrow reg=0;
  - D=0, Bout=0, ovf=0, out_valid=0.
  - Transfers are ignored while rst_n is low.
- in_ready = (state==IDLE), combinational. out_valid = (state==DONE), registered.
- States:
  - IDLE: on in_valid&&in_ready, latch A, B, Bin; borrow reg<=Bin; cnt<=0; go to BUSY.
  - BUSY: each cycle process slice k=cnt (bits 4k+3..4k):
    - g_i = ~a_i & b_i; p_i = ~(a_i ^ b_i).
    - Four look-ahead borrows from borrow reg, flattened two-level: b1 = g0|p0&b0, b2 = g1|p1&g0|p1&p0&b0, and so on.
    - d_i = a_i^b_i^b_i(in).
    - Write the slice into the D register; borrow reg <= slice borrow-out; cnt++.
    - When cnt==NSLICE-1: Bout<=slice borrow-out; go to DONE.
  - DONE: D, Bout, ovf held stable while out_ready=0. On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency and throughput:
  - Accept edge = cycle 0; out_valid is high after edge NSLICE (4 for WIDTH=16).
  - in_ready returns one cycle after the output handshake; there is no bypass accepting new operands in the DONE->IDLE cycle.
  - Maximum throughput is one operation per NSLICE+2 cycles.
- D is not cleared between operations. During BUSY, D holds a mix of new low slices and old high slices; it is only meaningful while out_valid=1.
- Wrap-around: the result is modulo 2^WIDTH; underflow is reported only via Bout.
- Input changes after the accept edge have no effect on the result.
- in_valid while BUSY or DONE is ignored: no queueing.
- Reset mid-operation (BUSY or DONE): the operation is aborted with no output; the next accepted operation computes correctly.

Optional Feature:
- Macro: BLS_OVF_EN.
- Defined: on the final slice, ovf <= (A[W-1]!=B[W-1]) && (d[W-1]!=A[W-1]), computed from the latched operands and the final slice's MSB result. ovf is held with D and cleared on reset.
- Not defined: ovf is tied to 0 and no overflow logic is synthesised. The port remains so the interface is identical.

Test Plan:
1. WIDTH=16: A=0x1234, B=0x0034, Bin=0 with out_ready=1 -> out_valid exactly 4 cycles after accept; D=0x1200, Bout=0.
2. A=0x0000, B=0x0001, Bin=0 -> D=0xFFFF, Bout=1; borrow propagates through all 4 slices.
3. A=0xABCD, B=0xABCD, Bin=1 -> D=0xFFFF, Bout=1. Same operands with Bin=0 -> D=0x0000, Bout=0.
4. A=0x8000, B=0x0001, Bin=0 -> D=0x7FFF, Bout=0, ovf=1 with BLS_OVF_EN and ovf=0 without. A=0x7FFF, B=0xFFFF -> D=0x8000, Bout=1, ovf=1 (macro on).
5. Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands -> D/Bout stable, in_ready=0, new operands ignored. After out_ready=1, in_ready=1 on the following cycle and the new op is accepted.
6. Reset: drop rst_n for 1 cycle during BUSY slice 2 -> next cycle out_valid=0, D=0, Bout=0, in_ready=1. Then A=0x00FF, B=0x0100 -> D=0xFFFF, Bout=1.
